// File: rtl/uc_multiciclo_if.sv
// uc_multiciclo_if: instruction fields, datapath flags and control strobes between the control unit and the MIPS datapath.
interface uc_multiciclo_if;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [31:0] Bvalue;
    logic        overflow;
    logic        overflow2;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IRWrite;
    logic        RegWrite;
    logic        AluOutWrite;
    logic        EPCWrite;
    logic        HIWrite;
    logic        LOWrite;
    logic        CauseWrite;
    logic        initMult;
    logic        initDiv;
    logic        AluSrcA;
    logic        MemReadOrWrite;
    logic [1:0]  PCSource;
    logic [1:0]  IorD;
    logic [1:0]  RegDst;
    logic [1:0]  MemToReg;
    logic [1:0]  AluSrcB;
    logic [2:0]  AluOp;
    logic [1:0]  BranchOp;
    logic [1:0]  ExceptionAddress;
    logic [1:0]  INTCause;

    modport master (
        input  Opcode, Funct, Bvalue, overflow, overflow2,
        output PCWrite, PCWriteCond, IRWrite, RegWrite, AluOutWrite, EPCWrite, HIWrite, LOWrite,
               CauseWrite, initMult, initDiv, AluSrcA, MemReadOrWrite, PCSource, IorD, RegDst,
               MemToReg, AluSrcB, AluOp, BranchOp, ExceptionAddress, INTCause
    );

    modport slave (
        output Opcode, Funct, Bvalue, overflow, overflow2,
        input  PCWrite, PCWriteCond, IRWrite, RegWrite, AluOutWrite, EPCWrite, HIWrite, LOWrite,
               CauseWrite, initMult, initDiv, AluSrcA, MemReadOrWrite, PCSource, IorD, RegDst,
               MemToReg, AluSrcB, AluOp, BranchOp, ExceptionAddress, INTCause
    );
endinterface

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: Moore multicycle control unit for the MIPS subset with memory/muldiv wait counting and precise exceptions.
module uc_multiciclo #(
    parameter int MEM_WAIT      = 2,
    parameter int MULDIV_CYCLES = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input logic            clk,
    input logic            reset,
    uc_multiciclo_if.master u
);
    localparam int MAXC = (MEM_WAIT > MULDIV_CYCLES) ? MEM_WAIT : MULDIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_WAIT - 1);
    localparam logic [CW-1:0] MD_LAST  = CW'(MULDIV_CYCLES - 1);

    typedef enum logic [4:0] {
        FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, ADDR, MEM_RD, WB_LW,
        MEM_WR, JUMP, MD_CHK, MD_INIT, MD_WAIT, MD_WB, EXC, EXC_RD, EXC_JMP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic [1:0]      cause_q, cause_d;

    // sel_q remembers the one bit each path needs later: sub, bne, sw or div
    logic r_type, f_add, f_sub, f_mul, f_div, mem_last, md_last;
    assign r_type   = u.Opcode == 6'h00;
    assign f_add    = r_type && u.Funct == 6'h20;
    assign f_sub    = r_type && u.Funct == 6'h22;
    assign f_mul    = ENABLE_MULDIV && r_type && u.Funct == 6'h18;
    assign f_div    = ENABLE_MULDIV && r_type && u.Funct == 6'h1a;
    assign mem_last = cnt_q == MEM_LAST;
    assign md_last  = cnt_q == MD_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cause_d = cause_q;
        case (state_q)
            FETCH:   state_d = mem_last ? DECODE : FETCH;
            DECODE: begin
                sel_d   = r_type ? (f_sub | f_div) : (u.Opcode == 6'h05 || u.Opcode == 6'h2b);
                cause_d = 2'b00;
                if (f_add || f_sub)                          state_d = EXEC_R;
                else if (f_mul || f_div)                     state_d = MD_CHK;
                else if (u.Opcode == 6'h08)                  state_d = EXEC_I;
                else if (u.Opcode == 6'h04 || u.Opcode == 6'h05) state_d = BRANCH;
                else if (u.Opcode == 6'h23 || u.Opcode == 6'h2b) state_d = ADDR;
                else if (u.Opcode == 6'h02)                  state_d = JUMP;
                else                                         state_d = EXC;
            end
            EXEC_R: begin
                cause_d = 2'b01;
                state_d = u.overflow ? EXC : WB_R;
            end
            EXEC_I: begin
                cause_d = 2'b01;
                state_d = u.overflow ? EXC : WB_I;
            end
            ADDR:    state_d = sel_q ? MEM_WR : MEM_RD;
            MEM_RD:  state_d = mem_last ? WB_LW : MEM_RD;
            MD_CHK: begin
                cause_d = 2'b10;
                state_d = (sel_q && u.Bvalue == 32'd0) ? EXC : MD_INIT;
            end
            MD_INIT: state_d = MD_WAIT;
            MD_WAIT: begin
                cause_d = 2'b01;
                state_d = md_last ? ((!sel_q && u.overflow2) ? EXC : MD_WB) : MD_WAIT;
            end
            EXC:     state_d = EXC_RD;
            EXC_RD:  state_d = mem_last ? EXC_JMP : EXC_RD;
            default: state_d = FETCH;
        endcase
        cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;
    end

    always_comb begin
        u.PCWrite          = 1'b0;
        u.PCWriteCond      = 1'b0;
        u.IRWrite          = 1'b0;
        u.RegWrite         = 1'b0;
        u.AluOutWrite      = 1'b0;
        u.EPCWrite         = 1'b0;
        u.HIWrite          = 1'b0;
        u.LOWrite          = 1'b0;
        u.CauseWrite       = 1'b0;
        u.initMult         = 1'b0;
        u.initDiv          = 1'b0;
        u.AluSrcA          = 1'b0;
        u.MemReadOrWrite   = 1'b0;
        u.PCSource         = 2'b00;
        u.IorD             = 2'b00;
        u.RegDst           = 2'b00;
        u.MemToReg         = 2'b00;
        u.AluSrcB          = 2'b00;
        u.AluOp            = 3'b000;
        u.BranchOp         = 2'b00;
        u.ExceptionAddress = 2'b00;
        u.INTCause         = 2'b00;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    u.AluSrcB = 2'b01;
                    u.AluOp   = 3'b001;
                    u.IRWrite = mem_last;
                    u.PCWrite = mem_last;
                end
                DECODE: begin
                    u.AluSrcB     = 2'b11;
                    u.AluOp       = 3'b001;
                    u.AluOutWrite = 1'b1;
                end
                EXEC_R: begin
                    u.AluSrcA     = 1'b1;
                    u.AluOp       = sel_q ? 3'b010 : 3'b001;
                    u.AluOutWrite = 1'b1;
                end
                WB_R: begin
                    u.RegDst   = 2'b01;
                    u.RegWrite = 1'b1;
                end
                EXEC_I, ADDR: begin
                    u.AluSrcA     = 1'b1;
                    u.AluSrcB     = 2'b10;
                    u.AluOp       = 3'b001;
                    u.AluOutWrite = 1'b1;
                end
                WB_I:    u.RegWrite = 1'b1;
                BRANCH: begin
                    u.AluSrcA     = 1'b1;
                    u.AluOp       = 3'b010;
                    u.PCWriteCond = 1'b1;
                    u.PCSource    = 2'b01;
                    u.BranchOp    = {1'b0, sel_q};
                end
                MEM_RD:  u.IorD = 2'b01;
                WB_LW: begin
                    u.MemToReg = 2'b01;
                    u.RegWrite = 1'b1;
                end
                MEM_WR: begin
                    u.IorD           = 2'b01;
                    u.MemReadOrWrite = 1'b1;
                end
                JUMP: begin
                    u.PCWrite  = 1'b1;
                    u.PCSource = 2'b10;
                end
                MD_INIT: begin
                    u.initMult = !sel_q;
                    u.initDiv  = sel_q;
                end
                MD_WB: begin
                    u.HIWrite = 1'b1;
                    u.LOWrite = 1'b1;
                end
                EXC: begin
                    u.EPCWrite         = 1'b1;
                    u.AluSrcB          = 2'b01;
                    u.AluOp            = 3'b010;
                    u.CauseWrite       = 1'b1;
                    u.INTCause         = cause_q;
                    u.ExceptionAddress = cause_q;
                end
                // the vector fetch needs the vector select held while memory answers
                EXC_RD: begin
                    u.IorD             = 2'b10;
                    u.ExceptionAddress = cause_q;
                end
                EXC_JMP: begin
                    u.PCWrite  = 1'b1;
                    u.PCSource = 2'b11;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: directed instruction sequences checked cycle by cycle against a per-instruction schedule model.
module tb_uc_multiciclo;
    localparam int MW = 2;
    localparam int MD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uc_multiciclo_if u1();
    uc_multiciclo_if u2();

    uc_multiciclo #(.MEM_WAIT(MW), .MULDIV_CYCLES(MD), .ENABLE_MULDIV(1'b1)) dut (
        .clk(clk), .reset(reset), .u(u1));
    uc_multiciclo #(.MEM_WAIT(MW), .MULDIV_CYCLES(MD), .ENABLE_MULDIV(1'b0)) dut_nomd (
        .clk(clk), .reset(reset), .u(u2));

    assign u2.Opcode    = u1.Opcode;
    assign u2.Funct     = u1.Funct;
    assign u2.Bvalue    = u1.Bvalue;
    assign u2.overflow  = u1.overflow;
    assign u2.overflow2 = u1.overflow2;

    typedef struct packed {
        logic pcw, pcwc, irw, rw, aow, epcw, hiw, low, cw, im, id, asa, mrw;
        logic [1:0] pcs, iord, rdst, m2r, asb;
        logic [2:0] aop;
        logic [1:0] bop, ea, ic;
    } ov_t;

    ov_t a1, a2;
    assign a1 = {u1.PCWrite, u1.PCWriteCond, u1.IRWrite, u1.RegWrite, u1.AluOutWrite, u1.EPCWrite,
                 u1.HIWrite, u1.LOWrite, u1.CauseWrite, u1.initMult, u1.initDiv, u1.AluSrcA,
                 u1.MemReadOrWrite, u1.PCSource, u1.IorD, u1.RegDst, u1.MemToReg, u1.AluSrcB,
                 u1.AluOp, u1.BranchOp, u1.ExceptionAddress, u1.INTCause};
    assign a2 = {u2.PCWrite, u2.PCWriteCond, u2.IRWrite, u2.RegWrite, u2.AluOutWrite, u2.EPCWrite,
                 u2.HIWrite, u2.LOWrite, u2.CauseWrite, u2.initMult, u2.initDiv, u2.AluSrcA,
                 u2.MemReadOrWrite, u2.PCSource, u2.IorD, u2.RegDst, u2.MemToReg, u2.AluSrcB,
                 u2.AluOp, u2.BranchOp, u2.ExceptionAddress, u2.INTCause};

    ov_t q[$];
    ov_t obs[$];
    ov_t obs2[$];
    int vectors = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ov_t e;
            e = q.pop_front();
            vectors++;
            if (a1 !== e) begin
                miscompares++;
                $display("FAIL cycle %0d of instr: got %h expected %h", obs.size() + 1, a1, e);
            end
            obs.push_back(a1);
            obs2.push_back(a2);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_fetch();
        ov_t v;
        for (int i = 0; i < MW; i++) begin
            v = '0;
            v.asb = 2'd1;
            v.aop = 3'd1;
            v.irw = (i == MW - 1);
            v.pcw = (i == MW - 1);
            q.push_back(v);
        end
    endtask

    task automatic push_exc(input logic [1:0] c);
        ov_t v;
        v = '0; v.epcw = 1'b1; v.asb = 2'd1; v.aop = 3'd2; v.cw = 1'b1; v.ic = c; v.ea = c;
        q.push_back(v);
        for (int i = 0; i < MW; i++) begin
            v = '0; v.iord = 2'd2; v.ea = c;
            q.push_back(v);
        end
        v = '0; v.pcw = 1'b1; v.pcs = 2'd3;
        q.push_back(v);
    endtask

    // Expected output schedule of one whole instruction, built from the instruction's phases
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] b,
                         input logic ovf, input logic ovf2);
        ov_t v;
        logic r, add, sub, mul, dv;
        r = op == 6'h00;
        add = r && fn == 6'h20;
        sub = r && fn == 6'h22;
        mul = r && fn == 6'h18;
        dv  = r && fn == 6'h1a;
        push_fetch();
        v = '0; v.asb = 2'd3; v.aop = 3'd1; v.aow = 1'b1;
        q.push_back(v);
        if (add || sub || op == 6'h08) begin
            v = '0; v.asa = 1'b1; v.aow = 1'b1;
            v.aop = sub ? 3'd2 : 3'd1;
            v.asb = (op == 6'h08) ? 2'd2 : 2'd0;
            q.push_back(v);
            if (ovf) push_exc(2'd1);
            else begin
                v = '0; v.rw = 1'b1; v.rdst = (op == 6'h08) ? 2'd0 : 2'd1;
                q.push_back(v);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            v = '0; v.asa = 1'b1; v.aop = 3'd2; v.pcwc = 1'b1; v.pcs = 2'd1;
            v.bop = (op == 6'h05) ? 2'd1 : 2'd0;
            q.push_back(v);
        end else if (op == 6'h23 || op == 6'h2b) begin
            v = '0; v.asa = 1'b1; v.asb = 2'd2; v.aop = 3'd1; v.aow = 1'b1;
            q.push_back(v);
            if (op == 6'h23) begin
                for (int i = 0; i < MW; i++) begin
                    v = '0; v.iord = 2'd1;
                    q.push_back(v);
                end
                v = '0; v.m2r = 2'd1; v.rw = 1'b1;
                q.push_back(v);
            end else begin
                v = '0; v.iord = 2'd1; v.mrw = 1'b1;
                q.push_back(v);
            end
        end else if (op == 6'h02) begin
            v = '0; v.pcw = 1'b1; v.pcs = 2'd2;
            q.push_back(v);
        end else if (mul || dv) begin
            v = '0;
            q.push_back(v);
            if (dv && b == 32'd0) push_exc(2'd2);
            else begin
                v = '0; v.im = mul; v.id = dv;
                q.push_back(v);
                for (int i = 0; i < MD; i++) begin
                    v = '0;
                    q.push_back(v);
                end
                if (mul && ovf2) push_exc(2'd1);
                else begin
                    v = '0; v.hiw = 1'b1; v.low = 1'b1;
                    q.push_back(v);
                end
            end
        end else push_exc(2'd0);
    endtask

    task automatic setup(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] b, input logic ovf, input logic ovf2, input int len);
        u1.Opcode = op;
        u1.Funct = fn;
        u1.Bvalue = b;
        u1.overflow = ovf;
        u1.overflow2 = ovf2;
        obs.delete();
        obs2.delete();
        model(op, fn, b, ovf, ovf2);
        check({nm, " length"}, q.size(), len);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: %0d cycles left, required 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] b, input logic ovf, input logic ovf2, input int len);
        setup(nm, op, fn, b, ovf, ovf2, len);
        drain(nm);
    endtask

    initial begin
        logic any_id;
        int n;
        u1.Opcode = 6'h00; u1.Funct = 6'h20; u1.Bvalue = 32'd5; u1.overflow = 1'b0; u1.overflow2 = 1'b0;
        #2;
        check("reset outputs zero", 32'(a1), 32'd0);
        check("reset outputs zero nomd", 32'(a2), 32'd0);
        setup("add", 6'h00, 6'h20, 32'd5, 1'b0, 1'b0, 5);
        @(posedge clk);
        #1 reset = 1'b0;
        drain("add");
        check("add IRWrite c2", 32'(obs[1].irw & obs[1].pcw), 32'd1);
        check("add RegWrite c5", 32'({obs[4].rw, obs[4].rdst}), 32'h5);

        run("sub", 6'h00, 6'h22, 32'd5, 1'b0, 1'b0, 5);
        check("sub AluOp", 32'(obs[3].aop), 32'd2);
        run("lw", 6'h23, 6'h00, 32'd5, 1'b0, 1'b0, 7);
        check("lw IorD c5-6", 32'({obs[4].iord, obs[5].iord}), 32'h5);
        check("lw wb c7", 32'({obs[6].rw, obs[6].m2r}), 32'h5);
        run("sw", 6'h2b, 6'h00, 32'd5, 1'b0, 1'b0, 5);
        check("sw write c5", 32'(obs[4].mrw), 32'd1);
        run("beq", 6'h04, 6'h00, 32'd5, 1'b0, 1'b0, 4);
        run("bne", 6'h05, 6'h00, 32'd5, 1'b0, 1'b0, 4);
        check("bne BranchOp", 32'(obs[3].bop), 32'd1);
        run("j", 6'h02, 6'h00, 32'd5, 1'b0, 1'b0, 4);
        run("addi", 6'h08, 6'h00, 32'd5, 1'b0, 1'b0, 5);
        run("addi ovf", 6'h08, 6'h00, 32'd5, 1'b1, 1'b0, 8);
        check("addi ovf no RegWrite", 32'(obs[4].rw | obs[3].rw), 32'd0);
        check("addi ovf cause", 32'({obs[4].epcw, obs[4].cw, obs[4].ic}), 32'hd);
        check("addi ovf vector read", 32'({obs[5].iord, obs[6].iord}), 32'ha);
        check("addi ovf vector jump", 32'({obs[7].pcw, obs[7].pcs}), 32'h7);
        run("add ovf", 6'h00, 6'h20, 32'd5, 1'b1, 1'b0, 8);
        run("undef 3f", 6'h3f, 6'h00, 32'd5, 1'b0, 1'b0, 7);
        check("undef cause", 32'({obs[3].cw, obs[3].ic}), 32'h4);
        run("mult", 6'h00, 6'h18, 32'd5, 1'b0, 1'b0, 10);
        check("mult init c5", 32'(obs[4].im), 32'd1);
        check("mult HI/LO c10", 32'({obs[9].hiw, obs[9].low}), 32'h3);
        check("nomd mult undef", 32'({obs2[3].epcw, obs2[3].cw, obs2[3].ic}), 32'hc);

        run("div b0", 6'h00, 6'h1a, 32'd0, 1'b0, 1'b0, 8);
        any_id = 1'b0;
        foreach (obs[i]) any_id |= obs[i].id;
        check("div0 no initDiv", 32'(any_id), 32'd0);
        check("div0 cause", 32'(obs[4].ic), 32'd2);
        run("div", 6'h00, 6'h1a, 32'd7, 1'b0, 1'b0, 10);
        check("div init c5", 32'(obs[4].id), 32'd1);
        run("mult ovf2", 6'h00, 6'h18, 32'd7, 1'b0, 1'b1, 13);

        setup("lw abort", 6'h23, 6'h00, 32'd5, 1'b0, 1'b0, 7);
        n = 0;
        while (obs.size() < 5 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort in MEM_RD", 32'(obs[4].iord), 32'd1);
        #1 reset = 1'b1;
        #1 check("reset mid zero", 32'(a1), 32'd0);
        q.delete();
        setup("add after reset", 6'h00, 6'h20, 32'd5, 1'b0, 1'b0, 5);
        @(posedge clk);
        #1 reset = 1'b0;
        drain("add after reset");
        check("restart IRWrite c2", 32'(obs[1].irw), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
